// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU types for the pipeline hazard controller: FSM state, register index,
// and the 8-bit pipeline control patterns {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {RUN, BUBBLE, DWAIT, HALTED} hz_state_t;
   typedef logic [4:0] regbits_t;

   localparam logic [7:0] CTL_NORM = 8'b1101_0101;
   localparam logic [7:0] CTL_BUB  = 8'b0001_1101;
   localparam logic [7:0] CTL_MISS = 8'b0111_0101;
   localparam logic [7:0] CTL_TAKE = 8'b1111_0101;
   localparam logic [7:0] CTL_RST  = 8'b0010_1010;
   localparam logic [7:0] CTL_FRZ  = 8'b0000_0000;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic reg_match(regbits_t rd, regbits_t rs, regbits_t rt, logic uses_rt);
      return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational register-compare logic: number of bubble cycles the instruction in ID needs.
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  regbits_t   id_rs,
   input  regbits_t   id_rt,
   input  logic       id_uses_rt,
   input  logic       id_branch,
   input  regbits_t   ex_rd,
   input  logic       ex_RegWr,
   input  logic       ex_MemRead,
   input  regbits_t   mem_rd,
   input  logic       mem_MemRead,
   output logic [1:0] haz_cnt
);

   logic ex_hit, mem_hit;

   always_comb begin
      ex_hit  = reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
      mem_hit = reg_match(mem_rd, id_rs, id_rt, id_uses_rt);
      haz_cnt = 2'd0;
      if (ex_MemRead && ex_hit)
         haz_cnt = 2'd1;
      // Branches resolve in ID, so they also wait on ALU results and on loads one stage further out.
      if (id_branch) begin
         if (ex_MemRead && ex_hit)
            haz_cnt = 2'd2;
         else if ((ex_RegWr && ex_hit) || (mem_MemRead && mem_hit))
            haz_cnt = 2'd1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles, flushes, data-miss freeze and halt.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dreq,
   input  logic        dhit,
   input  logic        halt,
   input  regbits_t    id_rs,
   input  regbits_t    id_rt,
   input  logic        id_uses_rt,
   input  logic        id_branch,
   input  logic        id_taken,
   input  regbits_t    ex_rd,
   input  logic        ex_RegWr,
   input  logic        ex_MemRead,
   input  regbits_t    mem_rd,
   input  logic        mem_MemRead,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        exmem_flush,
   output logic        memwb_en,
   output logic        halted
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   hz_state_t  state_q, state_d;
   logic [1:0] bub_cnt_q, bub_cnt_d;
   logic [1:0] haz_cnt;
   logic [7:0] ctl;
   logic       freeze, eff_bub;

   hazard_detect u_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .id_branch   (id_branch),
      .ex_rd       (ex_rd),
      .ex_RegWr    (ex_RegWr),
      .ex_MemRead  (ex_MemRead),
      .mem_rd      (mem_rd),
      .mem_MemRead (mem_MemRead),
      .haz_cnt     (haz_cnt)
   );

   // bub_cnt holds the bubbles still owed after the current one.
   always_comb begin
      state_d   = state_q;
      bub_cnt_d = bub_cnt_q;
      ctl       = CTL_NORM;
      halted    = 1'b0;
      freeze    = dreq && !dhit;
      eff_bub   = (state_q == BUBBLE) || ((state_q == DWAIT) && (bub_cnt_q != 2'd0));
      if (state_q == HALTED) begin
         ctl    = CTL_FRZ;
         halted = 1'b1;
      end else if (freeze) begin
         ctl     = CTL_FRZ;
         state_d = DWAIT;
      end else begin
         if (eff_bub) begin
            ctl       = CTL_BUB;
            bub_cnt_d = bub_cnt_q - 2'd1;
            state_d   = (bub_cnt_q == 2'd1) ? RUN : BUBBLE;
         end else if (haz_cnt != 2'd0) begin
            ctl       = CTL_BUB;
            bub_cnt_d = haz_cnt - 2'd1;
            state_d   = (haz_cnt == 2'd1) ? RUN : BUBBLE;
         end else begin
            state_d = RUN;
            if (!ihit)
               ctl = CTL_MISS;
            else if (id_taken)
               ctl = CTL_TAKE;
         end
         if (halt)
            state_d = HALTED;
      end
      if (RST) begin
         ctl    = CTL_RST;
         halted = 1'b0;
      end
      {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en} = ctl;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= RUN;
         bub_cnt_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         bub_cnt_q <= bub_cnt_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Only a taken redirect flushes IF/ID while the PC keeps advancing.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en && (state_q != HALTED) && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (pc_en && ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF))
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // Statistics counters are not built.
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL expose ports: CLK in 1 (rising edge); RST in 1 (synchronous, active-high).
REQ-002 SHALL take inputs: ihit 1 (fetch done); dreq 1 (MEM-stage load/store pending); dhit 1 (data access done); halt 1 (halt instruction in MEM).
REQ-003 SHALL take inputs: id_rs 5 and id_rt 5 (ID source registers); id_uses_rt 1; id_branch 1 (beq/bne/jr in ID); id_taken 1 (ID redirects PC).
REQ-004 SHALL take inputs: ex_rd 5, ex_RegWr 1, ex_MemRead 1 (EX destination); mem_rd 5, mem_MemRead 1 (MEM destination).
REQ-005 SHALL drive outputs, each 1 bit: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted.

Function
REQ-006 SHALL hold state in hz_state_t {RUN, BUBBLE, DWAIT, HALTED} plus a 2-bit bubble counter bub_cnt; all outputs combinational from state and inputs.
REQ-007 SHALL apply output priority: HALTED > freeze (dreq && !dhit) > BUBBLE > fetch miss (!ihit) > taken redirect > normal.
REQ-008 SHALL on freeze drive all *_en=0 and all *_flush=0, enter/stay DWAIT, and hold bub_cnt unchanged.
REQ-009 SHALL in DWAIT with dhit=1 drive the non-frozen outputs for the saved context, then go to BUBBLE if bub_cnt!=0, else RUN.
REQ-010 SHALL in RUN with no freeze, count hazards with ex_rd!=0 and mem_rd!=0 only: load-use (ex_MemRead, ex_rd==id_rs or id_uses_rt and ex_rd==id_rt) -> 1; id_branch with ex_RegWr && !ex_MemRead on match -> 1; id_branch with ex_MemRead on match -> 2; id_branch with mem_MemRead and mem_rd match -> 1.
REQ-011 SHALL on a nonzero hazard count load bub_cnt with it, drive the bubble pattern that cycle, go to BUBBLE if count-1!=0, else stay RUN.
REQ-012 SHALL define the bubble pattern as pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1, memwb_en=1.
REQ-013 SHALL in BUBBLE drive the bubble pattern without re-evaluating hazards, decrement bub_cnt per unfrozen cycle, and return to RUN after the cycle bub_cnt reaches 0.
REQ-014 SHALL on fetch miss (RUN, no hazard) drive pc_en=0, ifid_flush=1, with all other enables 1.
REQ-015 SHALL on id_taken in RUN with no hazard and ihit=1 drive ifid_flush=1, with all enables 1; id_taken during a bubble or freeze SHALL be ignored.
REQ-016 SHALL in normal operation drive all *_en=1 and all *_flush=0.
REQ-017 SHALL on halt=1 with no freeze enter HALTED the next cycle; HALTED is sticky until RST, drives halted=1, all *_en=0, all *_flush=0.

Reset
REQ-018 SHALL while RST=1 drive all *_en=0, all *_flush=1 and halted=0; on the first edge with RST=1, state=RUN and bub_cnt=0, including mid-BUBBLE or mid-DWAIT.

Configuration
REQ-019 SHALL with HAZARD_STATS_EN defined add outputs stall_cnt 32 and flush_cnt 32, both reset to 0.
REQ-020 SHALL increment stall_cnt each cycle pc_en=0 outside RST and HALTED, and flush_cnt each taken-redirect flush; both saturate at 0xFFFFFFFF.
REQ-021 SHALL with HAZARD_STATS_EN undefined omit these ports and counters entirely.

Structure
REQ-022 SHALL place hz_state_t and the 5-bit regbits_t in the shared cpu types package.
REQ-023 SHALL isolate the register-compare logic of REQ-010 in a combinational sub-module hazard_detect that outputs a 2-bit hazard count.

Verification
REQ-024 Load-use: EX lw ex_rd=8, ID add id_rs=8 -> one cycle pc_en=0, idex_flush=1, then normal.
REQ-025 Branch on load: EX lw ex_rd=9, ID beq id_rt=9, id_uses_rt=1 -> two bubble cycles, state RUN->BUBBLE->RUN.
REQ-026 Freeze in BUBBLE: bub_cnt=1, dreq=1, dhit=0 for 3 cycles -> all en=0 for 3 cycles, then the remaining bubble executes.
REQ-027 Taken branch: id_taken=1, no hazard, ihit=1 -> ifid_flush=1 for one cycle; flush_cnt=1 with HAZARD_STATS_EN.
REQ-028 Halt: halt=1, dreq=0 -> halted=1 the next cycle and stays until RST; RST asserted mid-DWAIT -> state RUN, outputs per REQ-018.
REQ-029 Zero register: ex_MemRead=1, ex_rd=0, id_rs=0 -> no bubble.
